// File: rtl/byte_word_packer.sv
// Byte-to-word width adapter: packs REPLICATION_FACTOR bytes (lane 0 first) into one
// registered word, padding and flagging a short final group terminated by in_last.
module byte_word_packer #(
    parameter int unsigned REPLICATION_FACTOR = 3,
    parameter logic [7:0]  PAD_BYTE           = 8'h00
) (
    input  logic                                   clock,
    input  logic                                   reset,
    input  logic [7:0]                             in_data,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    input  logic                                   in_last,
    output logic [8*REPLICATION_FACTOR-1:0]        out_data,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic                                   out_last,
    output logic [$clog2(REPLICATION_FACTOR+1)-1:0] out_count
);

    localparam int unsigned R         = REPLICATION_FACTOR;
    localparam int unsigned CNT_W     = (R > 1) ? $clog2(R) : 1;
    localparam int unsigned OUT_CNT_W = $clog2(R + 1);

    logic [R-1:0][7:0] acc;
    logic [CNT_W-1:0]  cnt;

    logic              in_fire;
    logic              out_fire;
    logic              word_done;
    logic [R-1:0][7:0] next_word;

    // NOTE: every signal written in always_comb gets a value on every path, otherwise a latch is inferred.
    always_comb begin
        in_ready  = ~out_valid | out_ready;
        in_fire   = in_valid & in_ready;
        out_fire  = out_valid & out_ready;
        word_done = in_fire & (in_last | (cnt == CNT_W'(R - 1)));

        next_word = '0;
        for (int k = 0; k < int'(R); k++) begin
            if (CNT_W'(k) < cnt) begin
                next_word[k] = acc[k];
            end else if (CNT_W'(k) == cnt) begin
                next_word[k] = in_data;
            end else begin
                next_word[k] = PAD_BYTE;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            acc       <= '0;
            cnt       <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_count <= '0;
        end else begin
            if (word_done) begin
                out_data  <= next_word;
                out_count <= OUT_CNT_W'(cnt) + OUT_CNT_W'(1);
                out_last  <= in_last;
                out_valid <= 1'b1;
                cnt       <= '0;
                acc       <= '0;
            end else begin
                // A drained word without a replacement leaves data/count as don't-care.
                if (out_fire) begin
                    out_valid <= 1'b0;
                end
                if (in_fire) begin
                    for (int k = 0; k < int'(R); k++) begin
                        if (CNT_W'(k) == cnt) begin
                            acc[k] <= in_data;
                        end
                    end
                    cnt <= cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_byte_word_packer.sv
// Self-checking bench for byte_word_packer (R=3): two instances (PAD 0x00 and 0xFF) share
// stimulus and are compared every cycle against a queue-based packing model.
module tb_byte_word_packer;

    localparam int R = 3;

    typedef struct {
        logic [23:0] da;
        logic [23:0] db;
        int          cnt;
        bit          last;
    } word_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic        out_ready = 1'b0;

    logic        in_ready_a, out_valid_a, out_last_a;
    logic [23:0] out_data_a;
    logic [1:0]  out_count_a;
    logic        in_ready_b, out_valid_b, out_last_b;
    logic [23:0] out_data_b;
    logic [1:0]  out_count_b;

    int n_checks = 0;
    int n_errors = 0;

    byte_word_packer #(.REPLICATION_FACTOR(R), .PAD_BYTE(8'h00)) dut_a (
        .clock(clk), .reset(rst),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready_a), .in_last(in_last),
        .out_data(out_data_a), .out_valid(out_valid_a), .out_ready(out_ready),
        .out_last(out_last_a), .out_count(out_count_a)
    );

    byte_word_packer #(.REPLICATION_FACTOR(R), .PAD_BYTE(8'hFF)) dut_b (
        .clock(clk), .reset(rst),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready_b), .in_last(in_last),
        .out_data(out_data_b), .out_valid(out_valid_b), .out_ready(out_ready),
        .out_last(out_last_b), .out_count(out_count_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: bytes collect in a group queue; a full or last-terminated group becomes a word.
    byte         grp[$];
    bit          m_valid;
    logic [23:0] m_data0, m_dataf;
    int          m_count;
    bit          m_last;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            grp.delete();
            m_valid = 0;
            m_data0 = '0;
            m_dataf = '0;
            m_count = 0;
            m_last  = 0;
        end else begin
            bit rdy;
            rdy = !m_valid || out_ready;
            if (m_valid && out_ready) m_valid = 0;
            if (in_valid && rdy) begin
                grp.push_back(in_data);
                if (grp.size() == R || in_last) begin
                    for (int i = 0; i < R; i++) begin
                        m_data0[8*i +: 8] = (i < grp.size()) ? grp[i] : 8'h00;
                        m_dataf[8*i +: 8] = (i < grp.size()) ? grp[i] : 8'hFF;
                    end
                    m_count = grp.size();
                    m_last  = in_last;
                    m_valid = 1;
                    grp.delete();
                end
            end
        end
    end

    word_t log_q[$];
    int    valid_cycles = 0;

    always @(negedge clk) begin
        if (!rst) begin
            check("in_ready_a", in_ready_a, !m_valid || out_ready);
            check("in_ready_b", in_ready_b, !m_valid || out_ready);
            check("out_valid_a", out_valid_a, m_valid);
            check("out_valid_b", out_valid_b, m_valid);
            if (m_valid) begin
                check("out_data_a", out_data_a, m_data0);
                check("out_data_b", out_data_b, m_dataf);
                check("out_count_a", out_count_a, m_count);
                check("out_count_b", out_count_b, m_count);
                check("out_last_a", out_last_a, m_last);
                check("out_last_b", out_last_b, m_last);
            end
            if (out_valid_a) valid_cycles++;
            if (out_valid_a && out_ready) begin
                word_t w;
                w.da = out_data_a;
                w.db = out_data_b;
                w.cnt = int'(out_count_a);
                w.last = out_last_a;
                log_q.push_back(w);
            end
        end
    end

    int stall_left   = 0;
    int stall_cycles = 0;

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            in_valid  = 1'b0;
            in_last   = 1'b0;
            out_ready = (stall_left == 0);
            @(posedge clk);
            #1;
            if (stall_left > 0) stall_left--;
        end
    endtask

    task automatic send_byte(input logic [7:0] d, input bit l);
        bit accepted = 0;
        int tries = 0;
        while (!accepted && tries < 50) begin
            in_valid  = 1'b1;
            in_data   = d;
            in_last   = l;
            out_ready = (stall_left == 0);
            #1;
            accepted = in_ready_a;
            if (!accepted) stall_cycles++;
            @(posedge clk);
            #1;
            if (stall_left > 0) stall_left--;
            tries++;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (!accepted) check("send_timeout", 0, 1);
    endtask

    task automatic check_word(input string name, input int idx, input logic [23:0] da,
                              input int cnt, input bit last);
        if (idx < log_q.size()) begin
            check({name, "_data"}, log_q[idx].da, da);
            check({name, "_count"}, log_q[idx].cnt, cnt);
            check({name, "_last"}, log_q[idx].last, last);
        end else begin
            check({name, "_missing"}, log_q.size(), idx + 1);
        end
    endtask

    initial begin
        int base;

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_in_ready", in_ready_a, 1);
        check("rst_out_valid", out_valid_a, 0);
        check("rst_out_data", out_data_a, 0);
        check("rst_out_count", out_count_a, 0);
        check("rst_out_last", out_last_a, 0);
        idle(10);
        check("idle_words", log_q.size(), 0);
        check("idle_valid", valid_cycles, 0);

        // Single full message.
        base = log_q.size();
        valid_cycles = 0;
        send_byte(8'h11, 0); send_byte(8'h22, 0); send_byte(8'h33, 1);
        check("t2_visible", out_valid_a, 1);
        idle(3);
        check("t2_valid_cycles", valid_cycles, 1);
        check("t2_words", log_q.size() - base, 1);
        check_word("t2_w0", base, 24'h332211, 3, 1);

        // Seven-byte stream, no backpressure.
        base = log_q.size();
        stall_cycles = 0;
        for (int i = 1; i <= 7; i++) send_byte(8'(i), i == 7);
        idle(3);
        check("t3_stalls", stall_cycles, 0);
        check("t3_words", log_q.size() - base, 3);
        check_word("t3_w0", base, 24'h030201, 3, 0);
        check_word("t3_w1", base + 1, 24'h060504, 3, 0);
        check_word("t3_w2", base + 2, 24'h000007, 1, 1);

        // Same stream with a 5-cycle output stall after the first word.
        base = log_q.size();
        stall_cycles = 0;
        for (int i = 1; i <= 7; i++) begin
            send_byte(8'(i), i == 7);
            if (i == 3) stall_left = 5;
        end
        idle(3);
        check("t4_stalls", stall_cycles, 5);
        check("t4_words", log_q.size() - base, 3);
        check_word("t4_w0", base, 24'h030201, 3, 0);
        check_word("t4_w1", base + 1, 24'h060504, 3, 0);
        check_word("t4_w2", base + 2, 24'h000007, 1, 1);

        // Short group: padding differs between the two instances.
        base = log_q.size();
        send_byte(8'hAA, 0); send_byte(8'hBB, 1);
        idle(3);
        check_word("t5_w0", base, 24'h00BBAA, 2, 1);
        if (base < log_q.size()) check("t5_pad_ff", log_q[base].db, 24'hFFBBAA);

        // Asynchronous reset mid-word.
        base = log_q.size();
        send_byte(8'h11, 0); send_byte(8'h22, 0);
        #3 rst = 1'b1;
        #1;
        check("t6_rst_valid", out_valid_a, 0);
        check("t6_rst_data", out_data_a, 0);
        check("t6_rst_count", out_count_a, 0);
        check("t6_rst_ready", in_ready_a, 1);
        @(posedge clk);
        #1 rst = 1'b0;
        send_byte(8'h44, 0); send_byte(8'h55, 0); send_byte(8'h66, 1);
        idle(3);
        check("t6_words", log_q.size() - base, 1);
        check_word("t6_w0", base, 24'h665544, 3, 1);

        // Random traffic and backpressure against the model.
        for (int i = 0; i < 1500; i++) begin
            in_valid  = ($urandom % 4) != 0;
            in_data   = 8'($urandom);
            in_last   = ($urandom % 5) == 0;
            out_ready = ($urandom % 3) != 0;
            @(posedge clk);
            #1;
        end
        idle(5);
        check("final_drained", out_valid_a, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/byte_word_packer.md
Name: byte_word_packer

Overview:
- Upstream width adapter that feeds `high_throughput_stateful_processor`.
- Accepts the 8-bit byte stream from the receive path using a valid/ready/last handshake.
- Packs REPLICATION_FACTOR consecutive bytes into one word and presents it on a registered valid/ready/last word interface.
- A short final group, terminated by in_last, is padded and flagged.

Parameters:
- REPLICATION_FACTOR, 3, bytes per output word. Must match the processor's REPLICATION_FACTOR. Must be >= 1.
- PAD_BYTE, 8'h00, value placed in unused upper byte lanes of a short final word.

Ports:
- clock  input  1  system clock; all state on rising edge
- reset  input  1  asynchronous, active-high; clears all state
- in_data  input  8  incoming byte
- in_valid  input  1  in_data valid
- in_ready  output  1  packer accepts a byte this cycle
- in_last  input  1  byte is the final byte of the message
- out_data  output  8*REPLICATION_FACTOR  packed word; byte k in bits [8k+7:8k]
- out_valid  output  1  out_data/out_last/out_count valid
- out_ready  input  1  downstream accepts the word
- out_last  output  1  word contains the final byte of the message
- out_count  output  $clog2(REPLICATION_FACTOR+1)  number of real bytes in word, 1..REPLICATION_FACTOR

Behaviour:
- The reset state (asynchronous, active-high) is as follows:
  - acc (accumulator) = 0 and lane counter cnt = 0.
  - out_valid = 0, out_data = 0, out_last = 0, out_count = 0.
  - in_ready follows its combinational equation and therefore reads 1 after reset.
- Reset asserted mid-word discards the partially packed bytes and any pending output word. No word is emitted for them.
- Byte accept (in_fire) = in_valid & in_ready.
- Word accept (out_fire) = out_valid & out_ready.
- in_ready = ~out_valid | out_ready. This is combinational from out_ready, with no other term. It gives full throughput with no bubble.
- Byte ordering: the first byte of a group goes to lane 0 (LSBs). Lane index = cnt at accept time.
- On in_fire with cnt < REPLICATION_FACTOR-1 and in_last = 0: write in_data into acc lane cnt, then cnt <= cnt+1. Output registers are untouched.
- On in_fire with cnt = REPLICATION_FACTOR-1, or with in_last = 1, the word completes:
  - out_data <= acc with lane cnt replaced by in_data. Lanes above cnt are set to PAD_BYTE.
  - out_count <= cnt+1; out_last <= in_last; out_valid <= 1.
  - cnt <= 0; acc <= 0.
- An in_last on a byte that also fills lane REPLICATION_FACTOR-1 gives a full word with out_last = 1 and out_count = REPLICATION_FACTOR. No extra empty word follows.
- Latency: out_valid rises on the clock edge that accepts the completing byte, i.e. the word is visible the cycle after that byte's handshake.
- Sustained rate: one byte per cycle in, one word every REPLICATION_FACTOR cycles out.
- Output hold: while out_valid = 1 and out_ready = 0, out_data, out_last and out_count are stable.
  - in_ready = 0 during a stall, so no bytes are accepted.
  - Stricter than needed for partial lanes, but required: it keeps the accept path single-rule.
- Simultaneous out_fire and a completing in_fire in the same cycle: the new word replaces the old one and out_valid stays 1.
- out_fire with no completing in_fire: out_valid <= 0. out_data and out_count hold their old values (don't-care).
- in_valid = 0 cycles: no state change except output drain. Gaps mid-word are allowed and do not affect packing.
- REPLICATION_FACTOR = 1: every accepted byte completes a word, with out_count = 1 always.
- No messages of zero bytes exist: in_last is only meaningful with in_valid.
- No enable input: the packer always runs; the gating is done downstream.

Test Plan:
- All tests use R = REPLICATION_FACTOR = 3.
- Reset, then idle:
  - in_ready = 1, out_valid = 0, out_data = 0.
  - Over 10 idle cycles, no output fires.
- Bytes 0x11,0x22,0x33 (last on 0x33) on consecutive cycles, out_ready = 1:
  - One word out_data = 0x332211, out_count = 3, out_last = 1.
  - out_valid is high for exactly one cycle, the cycle after 0x33 is accepted.
- Stream 0x01..0x07 with last on 0x07, out_ready = 1:
  - Words 0x030201 (count 3, last 0), then 0x060504 (count 3, last 0), then 0x000007 (count 1, last 1, PAD 0x00).
  - No input stalls.
- Same stream as above, with out_ready = 0 for 5 cycles after the first word appears:
  - First word held stable; in_ready = 0 throughout the stall; no bytes lost.
  - After release, the remaining words match the previous test exactly.
- PAD_BYTE = 8'hFF; bytes 0xAA,0xBB with last on 0xBB:
  - out_data = 0xFFBBAA, out_count = 2, out_last = 1.
- Reset pulse asserted asynchronously (mid-cycle) after 0x11,0x22 are accepted:
  - Outputs clear immediately.
  - Then sending 0x44,0x55,0x66 (last) gives exactly one word, 0x665544; no trace of 0x11/0x22.
